// File: rtl/rs.sv
// ----------------------------------------------------------------------------
// rs : reservation station for the out-of-order RISC-V core.
//
// Holds issued integer, branch and jump instructions until both operands are
// known. Missing operands are captured from the ROB commit broadcast. One
// ready entry is executed per cycle and its result is sent to the ROB.
//
// Ports
//   clk_in, rst_in            clock, synchronous active-high reset
//   rdy_in                    global enable (low: all state and outputs hold)
//   clear                     pipeline flush, drops every entry
//   from_decoder*             issue request and instruction fields
//   to_decoder_full           all entries busy (combinational)
//   from_rob_update*          commit broadcast (tag + value)
//   to_rob*                   registered result: valid pulse, entry index,
//                             ROB tag, op, rd, result value, next PC
// ----------------------------------------------------------------------------
module rs #(
    parameter int ROB_WIDTH = 4,
    parameter int RS_WIDTH  = 2,
    parameter int RS_SIZE   = 4
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    input  logic                 rdy_in,
    input  logic                 clear,
    input  logic                 from_decoder,
    input  logic [ROB_WIDTH-1:0] from_decoder_tag,
    input  logic [2:0]           from_decoder_op,
    input  logic [3:0]           from_decoder_func,
    input  logic [4:0]           from_decoder_rd,
    input  logic [31:0]          from_decoder_vj,
    input  logic [31:0]          from_decoder_vk,
    input  logic                 from_decoder_qj_busy,
    input  logic                 from_decoder_qk_busy,
    input  logic [ROB_WIDTH-1:0] from_decoder_qj,
    input  logic [ROB_WIDTH-1:0] from_decoder_qk,
    input  logic [31:0]          from_decoder_imm,
    input  logic [31:0]          from_decoder_pc,
    output logic                 to_decoder_full,
    input  logic                 from_rob_update,
    input  logic [ROB_WIDTH-1:0] from_rob_update_tag,
    input  logic [31:0]          from_rob_update_wdata,
    output logic                 to_rob,
    output logic [RS_WIDTH-1:0]  to_rob_index,
    output logic [ROB_WIDTH-1:0] to_rob_tag,
    output logic [2:0]           to_rob_op,
    output logic [4:0]           to_rob_rd,
    output logic [31:0]          to_rob_wdata,
    output logic [31:0]          to_rob_jump
);

    localparam logic [2:0] OP_WRITE   = 3'd0;
    localparam logic [2:0] OP_JUMP    = 3'd1;
    localparam logic [2:0] OP_BOTH    = 3'd2;
    localparam logic [2:0] OP_NOTHING = 3'd4;

    // Integer ALU for WRITE-class instructions; codes above SLTU yield zero.
    function automatic logic [31:0] alu_f(input logic [3:0] func,
                                          input logic [31:0] a,
                                          input logic [31:0] b);
        logic [31:0] r;
        case (func)
            4'd0:    r = a + b;
            4'd1:    r = a - b;
            4'd2:    r = a & b;
            4'd3:    r = a | b;
            4'd4:    r = a ^ b;
            4'd5:    r = a << b[4:0];
            4'd6:    r = a >> b[4:0];
            4'd7:    r = $unsigned($signed(a) >>> b[4:0]);
            4'd8:    r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'd9:    r = (a < b) ? 32'd1 : 32'd0;
            default: r = 32'd0;
        endcase
        return r;
    endfunction

    // Branch condition for codes BEQ..BGEU; any other code is not taken.
    function automatic logic taken_f(input logic [3:0] func,
                                     input logic [31:0] a,
                                     input logic [31:0] b);
        logic t;
        case (func)
            4'd10:   t = (a == b);
            4'd11:   t = (a != b);
            4'd12:   t = ($signed(a) < $signed(b));
            4'd13:   t = ($signed(a) >= $signed(b));
            4'd14:   t = (a < b);
            4'd15:   t = (a >= b);
            default: t = 1'b0;
        endcase
        return t;
    endfunction

    // Entry storage; busy and operand-pending flags are packed for reductions.
    logic [RS_SIZE-1:0]   busy_r;
    logic [RS_SIZE-1:0]   qj_busy_r;
    logic [RS_SIZE-1:0]   qk_busy_r;
    logic [ROB_WIDTH-1:0] tag_r  [RS_SIZE];
    logic [2:0]           op_r   [RS_SIZE];
    logic [3:0]           func_r [RS_SIZE];
    logic [4:0]           rd_r   [RS_SIZE];
    logic [31:0]          vj_r   [RS_SIZE];
    logic [31:0]          vk_r   [RS_SIZE];
    logic [ROB_WIDTH-1:0] qj_r   [RS_SIZE];
    logic [ROB_WIDTH-1:0] qk_r   [RS_SIZE];
    logic [31:0]          imm_r  [RS_SIZE];
    logic [31:0]          pc_r   [RS_SIZE];

    logic [RS_SIZE-1:0]  ready_s;
    logic                full_s;
    logic                sel_valid_s;
    logic [RS_WIDTH-1:0] sel_idx_s;
    logic [RS_WIDTH-1:0] free_idx_s;
    logic                taken_s;
    logic [31:0]         res_wdata_s;
    logic [31:0]         res_jump_s;
    logic                bypass_j_s;
    logic                bypass_k_s;

    assign to_decoder_full = full_s;

    // Ready/full flags and lowest-index pick of the selected and free entries.
    always_comb begin
        ready_s     = busy_r & ~qj_busy_r & ~qk_busy_r;
        full_s      = &busy_r;
        sel_valid_s = |ready_s;
        sel_idx_s   = '0;
        free_idx_s  = '0;
        // Scanning downward lets the lowest matching index win.
        for (int i = RS_SIZE - 1; i >= 0; i--) begin
            sel_idx_s  = ready_s[i] ? RS_WIDTH'(i) : sel_idx_s;
            free_idx_s = busy_r[i]  ? free_idx_s   : RS_WIDTH'(i);
        end
    end

    // Issuing operand captured straight from a same-cycle broadcast.
    always_comb begin
        bypass_j_s = from_rob_update && from_decoder_qj_busy &&
                     (from_decoder_qj == from_rob_update_tag);
        bypass_k_s = from_rob_update && from_decoder_qk_busy &&
                     (from_decoder_qk == from_rob_update_tag);
    end

    // Execute the selected entry according to its result class.
    always_comb begin
        taken_s = taken_f(func_r[sel_idx_s], vj_r[sel_idx_s], vk_r[sel_idx_s]);
        case (op_r[sel_idx_s])
            OP_WRITE: begin
                res_wdata_s = alu_f(func_r[sel_idx_s], vj_r[sel_idx_s], vk_r[sel_idx_s]);
                res_jump_s  = 32'd0;
            end
            OP_JUMP: begin
                res_wdata_s = {31'd0, taken_s};
                res_jump_s  = taken_s ? (pc_r[sel_idx_s] + imm_r[sel_idx_s])
                                      : (pc_r[sel_idx_s] + 32'd4);
            end
            OP_BOTH: begin
                // jal/jalr: link address, target with bit 0 forced low.
                res_wdata_s = pc_r[sel_idx_s] + 32'd4;
                res_jump_s  = (vj_r[sel_idx_s] + imm_r[sel_idx_s]) & 32'hFFFF_FFFE;
            end
            default: begin
                res_wdata_s = 32'd0;
                res_jump_s  = pc_r[sel_idx_s] + 32'd4;
            end
        endcase
    end

    // Entry state and registered ROB result: reset, flush, wakeup, select, issue.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            busy_r       <= '0;
            qj_busy_r    <= '0;
            qk_busy_r    <= '0;
            to_rob       <= 1'b0;
            to_rob_index <= '0;
            to_rob_tag   <= '0;
            to_rob_op    <= OP_NOTHING;
            to_rob_rd    <= 5'd0;
            to_rob_wdata <= 32'd0;
            to_rob_jump  <= 32'd0;
        end else if (rdy_in) begin
            if (clear) begin
                busy_r <= '0;
                to_rob <= 1'b0;
            end else begin
                // Wakeup: busy entries waiting on the committing tag capture it.
                for (int i = 0; i < RS_SIZE; i++) begin
                    if (from_rob_update && busy_r[i]) begin
                        if (qj_busy_r[i] && (qj_r[i] == from_rob_update_tag)) begin
                            vj_r[i]      <= from_rob_update_wdata;
                            qj_busy_r[i] <= 1'b0;
                        end
                        if (qk_busy_r[i] && (qk_r[i] == from_rob_update_tag)) begin
                            vk_r[i]      <= from_rob_update_wdata;
                            qk_busy_r[i] <= 1'b0;
                        end
                    end
                end

                if (sel_valid_s) begin
                    busy_r[sel_idx_s] <= 1'b0;
                    to_rob            <= 1'b1;
                    to_rob_index      <= sel_idx_s;
                    to_rob_tag        <= tag_r[sel_idx_s];
                    to_rob_op         <= op_r[sel_idx_s];
                    to_rob_rd         <= rd_r[sel_idx_s];
                    to_rob_wdata      <= res_wdata_s;
                    to_rob_jump       <= res_jump_s;
                end else begin
                    to_rob <= 1'b0;
                end

                // The free entry is never busy, so it cannot collide with select.
                if (from_decoder && !full_s) begin
                    busy_r[free_idx_s]    <= 1'b1;
                    tag_r[free_idx_s]     <= from_decoder_tag;
                    op_r[free_idx_s]      <= from_decoder_op;
                    func_r[free_idx_s]    <= from_decoder_func;
                    rd_r[free_idx_s]      <= from_decoder_rd;
                    imm_r[free_idx_s]     <= from_decoder_imm;
                    pc_r[free_idx_s]      <= from_decoder_pc;
                    qj_r[free_idx_s]      <= from_decoder_qj;
                    qk_r[free_idx_s]      <= from_decoder_qk;
                    vj_r[free_idx_s]      <= bypass_j_s ? from_rob_update_wdata : from_decoder_vj;
                    vk_r[free_idx_s]      <= bypass_k_s ? from_rob_update_wdata : from_decoder_vk;
                    qj_busy_r[free_idx_s] <= from_decoder_qj_busy && !bypass_j_s;
                    qk_busy_r[free_idx_s] <= from_decoder_qk_busy && !bypass_k_s;
                end
            end
        end
    end

endmodule

// File: doc/rs.md
# rs

Reservation station for the out-of-order RISC-V core. It sits between the decoder and the reorder buffer. It accepts issued integer, branch and jump instructions tagged with their ROB slot, and holds them until both operands are available. It captures missing operands from the ROB commit broadcast, executes one ready instruction per cycle, and writes the result into the ROB entry.

## Interface
Parameters:
- ROB_WIDTH, 4, ROB tag width.
- RS_WIDTH, 2, station index width.
- RS_SIZE, 4, number of station entries (2^RS_WIDTH).

Ports:
- clk_in  in  1  clock
- rst_in  in  1  reset; synchronous, active-high
- rdy_in  in  1  global enable; low means the block holds all state and outputs
- clear  in  1  pipeline flush
- from_decoder  in  1  issue valid
- from_decoder_tag  in  ROB_WIDTH  destination ROB slot
- from_decoder_op  in  3  result class: WRITE=0, JUMP=1, BOTH=2, NOTHING=4
- from_decoder_func  in  4  function code: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLL, 6 SRL, 7 SRA, 8 SLT, 9 SLTU, 10 BEQ, 11 BNE, 12 BLT, 13 BGE, 14 BLTU, 15 BGEU
- from_decoder_rd  in  5  destination register
- from_decoder_vj, from_decoder_vk  in  32  operand values
- from_decoder_qj_busy, from_decoder_qk_busy  in  1  operand pending
- from_decoder_qj, from_decoder_qk  in  ROB_WIDTH  producer tags
- from_decoder_imm  in  32  branch/jump offset
- from_decoder_pc  in  32  instruction PC
- to_decoder_full  out  1  all entries busy
- from_rob_update  in  1  commit broadcast valid
- from_rob_update_tag  in  ROB_WIDTH  committing ROB tag
- from_rob_update_wdata  in  32  committed value
- to_rob  out  1  result valid, one-cycle pulse
- to_rob_index  out  RS_WIDTH  entry that produced the result
- to_rob_tag  out  ROB_WIDTH  ROB slot
- to_rob_op  out  3  copied from the entry's op
- to_rob_rd  out  5  copied from the entry's rd
- to_rob_wdata  out  32  result value
- to_rob_jump  out  32  next PC

## Operation
Each entry holds busy, tag, op, func, rd, vj/qj/qj_busy, vk/qk/qk_busy, imm and pc.

- **Issue:** if from_decoder=1 and to_decoder_full=0, the instruction is written into the lowest-index non-busy entry. If from_decoder=1 while full, the issue is dropped; the decoder must not do this.
- **Issue bypass:** if a broadcast in the same cycle matches the issuing qj or qk while the corresponding busy bit is set, the entry stores the broadcast wdata and that operand is stored as ready.
- **Wakeup:** every busy entry with qj_busy and qj==from_rob_update_tag sets vj to the broadcast wdata and clears qj_busy. qk is handled the same way.
- **Select:** the lowest-index entry that is busy with qj_busy=0 and qk_busy=0, judged from registered state, is executed. Its busy bit is cleared in the same edge.

Execute, per op:
- **WRITE:** wdata = ALU(func, vj, vk). Shift amount is vk[4:0]. SLT is signed, SLTU unsigned. The jump output is 0.
- **JUMP:** the branch compare uses func 10-15 on vj and vk. jump = taken ? pc+imm : pc+4. wdata = taken (0/1).
- **BOTH:** jal/jalr. wdata = pc+4; jump = (vj+imm) & ~1. For JAL the decoder supplies vj=pc.
- **NOTHING, or any other op:** wdata=0, jump=pc+4.

All additions wrap modulo 2^32.

- **Full:** to_decoder_full is combinational and equals 1 when all RS_SIZE busy bits are set. It is computed from state before the edge, so an entry freed by select in the same cycle does not admit an issue.
- **Clear:** all busy bits are cleared and to_rob=0 at the next edge. Clear dominates issue, wakeup and select in that cycle.

## Timing
- Reset values: every busy bit 0, to_rob=0, to_rob_index=0, to_rob_tag=0, to_rob_op=4, to_rob_rd=0, to_rob_wdata=0, to_rob_jump=0; to_decoder_full=0.
- Issue at edge N with both operands ready: the entry is selected in cycle N+1 and to_rob is high for the cycle after edge N+1.
- An operand woken at edge M makes its entry selectable in cycle M+1, with the result after edge M+1.
- At most one result per cycle. to_rob deasserts unless another entry is selected.
- rdy_in=0: no state changes, and outputs hold their values, including a held to_rob.
- Reset or clear in mid-operation discards all entries. No result is emitted for them.

## Test plan
- **Reset, then a ready ADD:** issue vj=5, vk=7, tag=3, rd=1. Required: one pulse after 2 edges with tag=3, rd=1, wdata=12, op=0, index=0.
- **Dependency wakeup:** issue SUB with qj_busy=1, qj=6, vk=1. Required: no result. Then broadcast tag=6, wdata=10. Required: result wdata=9 one cycle after the broadcast edge.
- **Fill to full:** four dependent issues. Required: to_decoder_full=1, and a fifth issue is ignored. Broadcast wakes entry 2 only. Required: index=2 is emitted and full drops.
- **Branch:** BLT with vj=-1, vk=1, pc=0x100, imm=0x20. Required: jump=0x120, wdata=1. BLTU with the same operands. Required: jump=0x104, wdata=0.
- **JALR:** vj=0x1003, imm=4, pc=0x40. Required: wdata=0x44, jump=0x1006, op=2.
- **Clear with issue and wakeup in the same cycle:** required: no to_rob afterwards, and to_decoder_full=0.
